// File: rtl/gray_led_pkg.sv
// Shared constants and state type for the Gray-code 7-segment LED bus (driver and monitor sides).
// Latency: n/a (definitions only); backpressure: n/a.
package gray_led_pkg;

    localparam logic [6:0] SEG_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_ONE   = 7'h06;
    localparam logic [7:0] SEG_MASK  = 8'h7F;
    localparam int         ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

endpackage

// File: rtl/led7_glyph_decoder.sv
// One-digit glyph decoder: segments {dp,g..a} -> Gray bit plus recognised flag; dp ignored.
// Latency: combinational; backpressure: none.
module led7_glyph_decoder
    import gray_led_pkg::*;
(
    input  logic [7:0] seg_i,
    output logic       bit_o,
    output logic       ok_o
);

    logic is_one;
    logic is_zero;

    assign is_one  = ((seg_i & SEG_MASK) == {1'b0, SEG_ONE});
    assign is_zero = ((seg_i & SEG_MASK) == {1'b0, SEG_ZERO});
    assign bit_o   = is_one;
    assign ok_o    = is_one | is_zero;

endmodule

// File: rtl/gray_led_monitor.sv
// Receive-side checker: decodes the LED bus to Gray/binary, tracks +1 sequence legality, lock and errors.
// Latency: 1 cycle from sample_en to registered outputs; backpressure: none, one sample per cycle.
module gray_led_monitor
    import gray_led_pkg::*;
#(
    parameter int LEDS_COUNT = 6,
    parameter int LOCK_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [LEDS_COUNT*8-1:0] in_leds,
    output logic [LEDS_COUNT-1:0]   gray,
    output logic [LEDS_COUNT-1:0]   bin,
    output logic                    valid,
    output logic                    glyph_err,
    output logic                    step_err,
    output logic                    locked,
    output logic [ERR_CNT_W-1:0]    err_count
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    logic [LEDS_COUNT-1:0] dec_gray;
    logic [LEDS_COUNT-1:0] dec_ok;
    logic [LEDS_COUNT-1:0] bin_new;
    logic                  is_hold;
    logic                  is_step;

    mon_state_e            state_q, state_d;
    logic [3:0]            good_q, good_d;
    logic [LEDS_COUNT-1:0] gray_q, gray_d;
    logic [LEDS_COUNT-1:0] bin_q, bin_d;
    logic                  valid_q, valid_d;
    logic                  gerr_q, gerr_d;
    logic                  serr_q, serr_d;
    logic                  locked_q, locked_d;
    logic [ERR_CNT_W-1:0]  errc_q, errc_d;

    for (genvar k = 0; k < LEDS_COUNT; k++) begin : g_digit
        led7_glyph_decoder u_dec (
            .seg_i (in_leds[8*k +: 8]),
            .bit_o (dec_gray[k]),
            .ok_o  (dec_ok[k])
        );
    end

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        bin_new = '0;
        bin_new[LEDS_COUNT-1] = dec_gray[LEDS_COUNT-1];
        for (int i = LEDS_COUNT - 2; i >= 0; i--) begin
            bin_new[i] = bin_new[i+1] ^ dec_gray[i];
        end
    end

    assign is_hold = (bin_new == bin_q);
    assign is_step = (bin_new == LEDS_COUNT'(bin_q + 1'b1));

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        gray_d   = gray_q;
        bin_d    = bin_q;
        valid_d  = 1'b0;
        gerr_d   = 1'b0;
        serr_d   = 1'b0;
        locked_d = locked_q;
        errc_d   = errc_q;
        if (sample_en) begin
            if (!(&dec_ok)) begin
                gerr_d = 1'b1;
            end else begin
                gray_d  = dec_gray;
                bin_d   = bin_new;
                valid_d = 1'b1;
                unique case (state_q)
                    SEARCH: begin
                        state_d = TRACK;
                        good_d  = '0;
                    end
                    TRACK: begin
                        if (is_step) begin
                            good_d = good_q + 4'd1;
                            if (good_q + 4'd1 >= LOCK_TARGET) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else if (!is_hold) begin
                            serr_d = 1'b1;
                            good_d = '0;
                            if (errc_q != '1) errc_d = errc_q + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!is_step && !is_hold) begin
                            serr_d   = 1'b1;
                            good_d   = '0;
                            locked_d = 1'b0;
                            state_d  = TRACK;
                            if (errc_q != '1) errc_d = errc_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = SEARCH;
                        good_d  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEARCH;
            good_q   <= '0;
            gray_q   <= '0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            gerr_q   <= 1'b0;
            serr_q   <= 1'b0;
            locked_q <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            gray_q   <= gray_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            gerr_q   <= gerr_d;
            serr_q   <= serr_d;
            locked_q <= locked_d;
            errc_q   <= errc_d;
        end
    end

    assign gray      = gray_q;
    assign bin       = bin_q;
    assign valid     = valid_q;
    assign glyph_err = gerr_q;
    assign step_err  = serr_q;
    assign locked    = locked_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_gray_led_monitor.sv
// Directed bench for gray_led_monitor: hand-computed Gray/binary sequences, lock, glyph errors, wrap, saturation, reset.
module tb_gray_led_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [47:0] in_leds = '0;
    logic [5:0]  gray;
    logic [5:0]  bin;
    logic        valid;
    logic        glyph_err;
    logic        step_err;
    logic        locked;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    gray_led_monitor #(.LEDS_COUNT(6), .LOCK_COUNT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .in_leds   (in_leds),
        .gray      (gray),
        .bin       (bin),
        .valid     (valid),
        .glyph_err (glyph_err),
        .step_err  (step_err),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] enc(input logic [5:0] g);
        logic [47:0] b;
        for (int k = 0; k < 6; k++) b[8*k +: 8] = g[k] ? 8'h06 : 8'h3F;
        return b;
    endfunction

    task automatic check_all(input string tag, input logic [5:0] eg, input logic [5:0] eb,
                             input logic ev, input logic ege, input logic ese,
                             input logic el, input logic [7:0] ec);
        check_eq({tag, ".gray"},      32'(gray),      32'(eg));
        check_eq({tag, ".bin"},       32'(bin),       32'(eb));
        check_eq({tag, ".valid"},     32'(valid),     32'(ev));
        check_eq({tag, ".glyph_err"}, 32'(glyph_err), 32'(ege));
        check_eq({tag, ".step_err"},  32'(step_err),  32'(ese));
        check_eq({tag, ".locked"},    32'(locked),    32'(el));
        check_eq({tag, ".err_count"}, 32'(err_count), 32'(ec));
    endtask

    // Drive one strobe at a falling edge, then check outputs at the next falling edge.
    task automatic sample_chk(input string tag, input logic [47:0] bus,
                              input logic [5:0] eg, input logic [5:0] eb,
                              input logic ev, input logic ege, input logic ese,
                              input logic el, input logic [7:0] ec);
        sample_en = 1'b1;
        in_leds   = bus;
        @(negedge clk);
        check_all(tag, eg, eb, ev, ege, ese, el, ec);
    endtask

    initial begin
        logic [47:0] bus;

        sample_en = 1'b1;
        in_leds   = 48'hDEAD_BEEF_1234;
        #12;
        check_all("reset", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        sample_en = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_all("idle_after_reset", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        sample_chk("s0", enc(6'd0), 6'd0, 6'd0, 1, 0, 0, 0, 8'd0);
        sample_chk("s1", enc(6'd1), 6'd1, 6'd1, 1, 0, 0, 0, 8'd0);
        sample_chk("s2", enc(6'd3), 6'd3, 6'd2, 1, 0, 0, 0, 8'd0);
        sample_chk("s3", enc(6'd2), 6'd2, 6'd3, 1, 0, 0, 0, 8'd0);
        sample_chk("s4_lock", enc(6'd6), 6'd6, 6'd4, 1, 0, 0, 1, 8'd0);
        sample_chk("hold1", enc(6'd6), 6'd6, 6'd4, 1, 0, 0, 1, 8'd0);
        sample_chk("hold2", enc(6'd6), 6'd6, 6'd4, 1, 0, 0, 1, 8'd0);

        sample_chk("skip", enc(6'd5), 6'd5, 6'd6, 1, 0, 1, 0, 8'd1);
        sample_chk("re1", enc(6'd4),  6'd4,  6'd7,  1, 0, 0, 0, 8'd1);
        sample_chk("re2", enc(6'd12), 6'd12, 6'd8,  1, 0, 0, 0, 8'd1);
        sample_chk("re3", enc(6'd13), 6'd13, 6'd9,  1, 0, 0, 0, 8'd1);
        sample_chk("re4_lock", enc(6'd15), 6'd15, 6'd10, 1, 0, 0, 1, 8'd1);

        bus = enc(6'd14);
        bus[23:16] = 8'h7F;
        sample_chk("glyph_bad", bus, 6'd15, 6'd10, 0, 1, 0, 1, 8'd1);
        bus = enc(6'd14);
        bus[7:0] = 8'hBF;
        sample_chk("dp_masked", bus, 6'd14, 6'd11, 1, 0, 0, 1, 8'd1);
        sample_en = 1'b0;
        in_leds   = enc(6'd40);
        @(negedge clk);
        check_all("no_strobe", 6'd14, 6'd11, 0, 0, 0, 1, 8'd1);

        sample_chk("to63", enc(6'b100000), 6'b100000, 6'd63, 1, 0, 1, 0, 8'd2);
        sample_chk("wrap0", enc(6'd0), 6'd0, 6'd0, 1, 0, 0, 0, 8'd2);

        for (int i = 0; i < 300; i++) begin
            sample_en = 1'b1;
            in_leds   = (i % 2 == 0) ? enc(6'd48) : enc(6'd0);
            @(negedge clk);
        end
        check_eq("sat.err_count", 32'(err_count), 32'd255);
        sample_chk("sat_more", enc(6'd48), 6'd48, 6'd32, 1, 0, 1, 0, 8'd255);

        sample_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 6'd0, 6'd0, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        sample_chk("post_rst_ref", enc(6'd5), 6'd5, 6'd6, 1, 0, 0, 0, 8'd0);
        sample_chk("post_rst_step", enc(6'd4), 6'd4, 6'd7, 1, 0, 0, 0, 8'd0);
        sample_en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
